// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use and branch-operand stalls, decode flush,
// a multi-cycle mult/div busy tracker, sticky start error and a stall counter.
module pipe_hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [4:0]       rs_d_i,
    input  logic [4:0]       rt_d_i,
    input  logic             branch_d_i,
    input  logic             pc_src_d_i,
    input  logic             jump_d_i,
    input  logic             mdu_use_d_i,
    input  logic             memtoreg_e_i,
    input  logic             regwrite_e_i,
    input  logic [4:0]       write_reg_e_i,
    input  logic             memtoreg_m_i,
    input  logic [4:0]       write_reg_m_i,
    input  logic             mdu_start_e_i,
    input  logic             mdu_div_e_i,
    output logic             stall_f_o,
    output logic             en_d_o,
    output logic             flush_d_o,
    output logic             flush_e_o,
    output logic             mdu_busy_o,
    output logic             mdu_done_o,
    output logic             mdu_err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int CW = $clog2(DIV_LAT + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic busy;
    logic done;
    logic e_hit;
    logic m_hit;
    logic lw_stall;
    logic br_stall;
    logic mdu_stall;
    logic stall_d;

    // MDU terms read as idle while reset is asserted so nothing stalls on them
    assign busy = (state_q == ST_BUSY) && !reset_i;
    assign done = busy && (cnt_q == '0);

    assign e_hit = (write_reg_e_i != 5'd0) &&
                   ((write_reg_e_i == rs_d_i) || (write_reg_e_i == rt_d_i));
    assign m_hit = (write_reg_m_i != 5'd0) &&
                   ((write_reg_m_i == rs_d_i) || (write_reg_m_i == rt_d_i));

    assign lw_stall  = memtoreg_e_i && e_hit;
    assign br_stall  = branch_d_i &&
                       ((regwrite_e_i && e_hit) || (memtoreg_m_i && m_hit));
    assign mdu_stall = mdu_use_d_i && busy;
    assign stall_d   = lw_stall || br_stall || mdu_stall;

    assign stall_f_o   = stall_d;
    assign en_d_o      = !stall_d;
    assign flush_e_o   = stall_d;
    assign flush_d_o   = (pc_src_d_i || jump_d_i) && !stall_d;
    assign mdu_busy_o  = busy;
    assign mdu_done_o  = done;
    assign mdu_err_o   = err_q;
    assign stall_cnt_o = stall_cnt_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        stall_cnt_d = stall_cnt_q;
        if (reset_i) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            err_d       = 1'b0;
            stall_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mdu_start_e_i) begin
                        state_d = ST_BUSY;
                        cnt_d   = mdu_div_e_i ? DIV_LOAD : MUL_LOAD;
                    end
                end
                ST_BUSY: begin
                    // a start while busy is dropped, only flagged
                    if (mdu_start_e_i) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
            if (stall_d && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        err_q       <= err_d;
        stall_cnt_q <= stall_cnt_d;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; a second instance with a
// 4-bit stall counter shares the stimulus and is used for saturation checks.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [4:0]  rs_d, rt_d, write_reg_e, write_reg_m;
    logic        branch_d, pc_src_d, jump_d, mdu_use_d;
    logic        memtoreg_e, regwrite_e, memtoreg_m;
    logic        mdu_start_e, mdu_div_e;

    logic        stall_f, en_d, flush_d, flush_e;
    logic        mdu_busy, mdu_done, mdu_err;
    logic [15:0] stall_cnt;

    logic        s_stall_f, s_en_d, s_flush_d, s_flush_e;
    logic        s_busy, s_done, s_err;
    logic [3:0]  s_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk_i(clk), .reset_i(reset_i),
        .rs_d_i(rs_d), .rt_d_i(rt_d),
        .branch_d_i(branch_d), .pc_src_d_i(pc_src_d), .jump_d_i(jump_d),
        .mdu_use_d_i(mdu_use_d),
        .memtoreg_e_i(memtoreg_e), .regwrite_e_i(regwrite_e),
        .write_reg_e_i(write_reg_e),
        .memtoreg_m_i(memtoreg_m), .write_reg_m_i(write_reg_m),
        .mdu_start_e_i(mdu_start_e), .mdu_div_e_i(mdu_div_e),
        .stall_f_o(stall_f), .en_d_o(en_d),
        .flush_d_o(flush_d), .flush_e_o(flush_e),
        .mdu_busy_o(mdu_busy), .mdu_done_o(mdu_done), .mdu_err_o(mdu_err),
        .stall_cnt_o(stall_cnt)
    );

    pipe_hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(4)) dut_s (
        .clk_i(clk), .reset_i(reset_i),
        .rs_d_i(rs_d), .rt_d_i(rt_d),
        .branch_d_i(branch_d), .pc_src_d_i(pc_src_d), .jump_d_i(jump_d),
        .mdu_use_d_i(mdu_use_d),
        .memtoreg_e_i(memtoreg_e), .regwrite_e_i(regwrite_e),
        .write_reg_e_i(write_reg_e),
        .memtoreg_m_i(memtoreg_m), .write_reg_m_i(write_reg_m),
        .mdu_start_e_i(mdu_start_e), .mdu_div_e_i(mdu_div_e),
        .stall_f_o(s_stall_f), .en_d_o(s_en_d),
        .flush_d_o(s_flush_d), .flush_e_o(s_flush_e),
        .mdu_busy_o(s_busy), .mdu_done_o(s_done), .mdu_err_o(s_err),
        .stall_cnt_o(s_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rs_d = 5'd0; rt_d = 5'd0; write_reg_e = 5'd0; write_reg_m = 5'd0;
        branch_d = 1'b0; pc_src_d = 1'b0; jump_d = 1'b0; mdu_use_d = 1'b0;
        memtoreg_e = 1'b0; regwrite_e = 1'b0; memtoreg_m = 1'b0;
        mdu_start_e = 1'b0; mdu_div_e = 1'b0;
    endtask

    initial begin
        clr();
        reset_i = 1'b1;
        step();
        step();
        reset_i = 1'b0;
        #1;
        chk("rst_busy", 32'(mdu_busy), 32'd0);
        chk("rst_done", 32'(mdu_done), 32'd0);
        chk("rst_err", 32'(mdu_err), 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_en_d", 32'(en_d), 32'd1);

        // load-use
        memtoreg_e = 1'b1; write_reg_e = 5'd8; rs_d = 5'd8; rt_d = 5'd2;
        #1;
        chk("lu_stall_f", 32'(stall_f), 32'd1);
        chk("lu_en_d", 32'(en_d), 32'd0);
        chk("lu_flush_e", 32'(flush_e), 32'd1);
        chk("lu_flush_d", 32'(flush_d), 32'd0);
        step();
        clr();
        #1;
        chk("lu_cnt", 32'(stall_cnt), 32'd1);
        chk("lu_release", 32'(stall_f), 32'd0);

        // load to r0 never stalls
        memtoreg_e = 1'b1; write_reg_e = 5'd0; rs_d = 5'd0;
        #1;
        chk("lu_r0", 32'(stall_f), 32'd0);
        step();
        chk("lu_r0_cnt", 32'(stall_cnt), 32'd1);
        clr();

        // branch operand from EX
        branch_d = 1'b1; regwrite_e = 1'b1; write_reg_e = 5'd9;
        rs_d = 5'd3; rt_d = 5'd9;
        #1;
        chk("br_e_stall", 32'(stall_f), 32'd1);
        chk("br_e_flush_e", 32'(flush_e), 32'd1);
        step();
        // branch operand from MEM load, taken but stalled
        regwrite_e = 1'b0; write_reg_e = 5'd0;
        memtoreg_m = 1'b1; write_reg_m = 5'd9; pc_src_d = 1'b1;
        #1;
        chk("br_m_stall", 32'(stall_f), 32'd1);
        chk("br_m_no_flush_d", 32'(flush_d), 32'd0);
        step();
        memtoreg_m = 1'b0; write_reg_m = 5'd0;
        #1;
        chk("br_flush_d", 32'(flush_d), 32'd1);
        chk("br_flush_e", 32'(flush_e), 32'd0);
        chk("br_en_d", 32'(en_d), 32'd1);
        chk("br_cnt", 32'(stall_cnt), 32'd3);
        // regwrite to r0 is not a hazard; jump flushes
        pc_src_d = 1'b0; jump_d = 1'b1; regwrite_e = 1'b1; write_reg_e = 5'd0;
        rt_d = 5'd0;
        #1;
        chk("br_r0", 32'(stall_f), 32'd0);
        chk("jmp_flush_d", 32'(flush_d), 32'd1);
        step();
        clr();

        // divide, dependent instruction held in D
        mdu_start_e = 1'b1; mdu_div_e = 1'b1; mdu_use_d = 1'b1;
        #1;
        chk("div_pre_en", 32'(en_d), 32'd1);
        step();
        mdu_start_e = 1'b0; mdu_div_e = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            #1;
            chk("div_busy", 32'(mdu_busy), 32'd1);
            chk("div_en_d", 32'(en_d), 32'd0);
            chk("div_done", 32'(mdu_done), (k == 32) ? 32'd1 : 32'd0);
            step();
        end
        chk("div_release_busy", 32'(mdu_busy), 32'd0);
        chk("div_release_en", 32'(en_d), 32'd1);
        chk("div_cnt", 32'(stall_cnt), 32'd35);
        clr();

        // multiply with a second start while busy
        mdu_start_e = 1'b1;
        step();
        mdu_start_e = 1'b0;
        #1;
        chk("mul_t1_busy", 32'(mdu_busy), 32'd1);
        chk("mul_t1_err", 32'(mdu_err), 32'd0);
        step();
        mdu_start_e = 1'b1; mdu_div_e = 1'b1;
        #1;
        chk("mul_t2_err", 32'(mdu_err), 32'd0);
        step();
        mdu_start_e = 1'b0; mdu_div_e = 1'b0;
        #1;
        chk("mul_t3_err", 32'(mdu_err), 32'd1);
        chk("mul_t3_done", 32'(mdu_done), 32'd0);
        step();
        chk("mul_t4_busy", 32'(mdu_busy), 32'd1);
        chk("mul_t4_done", 32'(mdu_done), 32'd1);
        step();
        chk("mul_t5_busy", 32'(mdu_busy), 32'd0);
        chk("mul_t5_err", 32'(mdu_err), 32'd1);
        step();
        chk("mul_err_sticky", 32'(mdu_err), 32'd1);

        // reset in the middle of a divide
        mdu_start_e = 1'b1; mdu_div_e = 1'b1;
        step();
        mdu_start_e = 1'b0; mdu_div_e = 1'b0;
        for (int k = 1; k < 10; k++) step();
        chk("rdiv_busy", 32'(mdu_busy), 32'd1);
        reset_i = 1'b1; mdu_use_d = 1'b1;
        #1;
        chk("rdiv_no_stall", 32'(en_d), 32'd1);
        step();
        reset_i = 1'b0; mdu_use_d = 1'b0;
        #1;
        chk("rdiv_busy0", 32'(mdu_busy), 32'd0);
        chk("rdiv_err0", 32'(mdu_err), 32'd0);
        chk("rdiv_cnt0", 32'(stall_cnt), 32'd0);
        chk("rdiv_scnt0", 32'(s_stall_cnt), 32'd0);
        for (int k = 0; k < 25; k++) begin
            chk("rdiv_no_done", 32'(mdu_done), 32'd0);
            step();
        end

        // every stall source at once, counter moves by one
        mdu_start_e = 1'b1;
        step();
        mdu_start_e = 1'b0;
        memtoreg_e = 1'b1; regwrite_e = 1'b1; write_reg_e = 5'd5;
        rs_d = 5'd5; branch_d = 1'b1; memtoreg_m = 1'b1; write_reg_m = 5'd5;
        mdu_use_d = 1'b1; pc_src_d = 1'b1; jump_d = 1'b1;
        #1;
        chk("all_flush_e", 32'(flush_e), 32'd1);
        chk("all_flush_d", 32'(flush_d), 32'd0);
        chk("all_stall_f", 32'(stall_f), 32'd1);
        step();
        chk("all_cnt", 32'(stall_cnt), 32'd1);
        clr();
        step(); step(); step();
        chk("all_idle", 32'(mdu_busy), 32'd0);

        // saturation on the 4-bit counter
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        memtoreg_e = 1'b1; write_reg_e = 5'd5; rs_d = 5'd5;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("sat_cnt", 32'(s_stall_cnt), (k < 15) ? 32'(k) : 32'd15);
        end
        chk("sat_wide_cnt", 32'(stall_cnt), 32'd20);
        clr();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline. It drives the enable and flush inputs of the IF/ID pipeline register and the clear input of the ID/EX register. Stall terms are combinational: load-use stalls and decode-stage branch-operand stalls. Sequential parts are a multi-cycle multiply/divide busy FSM with a latency countdown, a sticky protocol-error flag, and a saturating stall-cycle performance counter.

## Interface
- MUL_LAT, 4: multiply latency in cycles (≥1)
- DIV_LAT, 32: divide latency in cycles (≥1, ≥MUL_LAT)
- CNT_W, 16: stall performance counter width

- clk_i  in  1  clock; all state updates on rising edge
- reset_i  in  1  synchronous, active-high reset
- rs_d_i, rt_d_i  in  5 each  source registers of the decode-stage instruction
- branch_d_i  in  1  decode instruction is a branch (operands compared in D)
- pc_src_d_i  in  1  branch taken, resolved in D
- jump_d_i  in  1  decode instruction is a jump
- mdu_use_d_i  in  1  decode instruction is mfhi/mflo/mult/div
- memtoreg_e_i, regwrite_e_i  in  1 each  execute-stage controls
- write_reg_e_i  in  5  execute-stage destination register
- memtoreg_m_i  in  1  memory-stage load
- write_reg_m_i  in  5  memory-stage destination register
- mdu_start_e_i  in  1  execute-stage instruction starts mult/div
- mdu_div_e_i  in  1  1 = divide, 0 = multiply (valid with start)
- stall_f_o  out  1  hold PC
- en_d_o  out  1  IF/ID enable (= ~stall_d)
- flush_d_o  out  1  IF/ID flush
- flush_e_o  out  1  ID/EX clear (inject bubble)
- mdu_busy_o  out  1  FSM in BUSY
- mdu_done_o  out  1  last busy cycle
- mdu_err_o  out  1  sticky: start seen while BUSY
- stall_cnt_o  out  CNT_W  saturating count of stalled cycles

## Operation
- Load-use: lw_stall = memtoreg_e_i & (write_reg_e_i≠0) & (write_reg_e_i==rs_d_i | write_reg_e_i==rt_d_i).
- Branch stall: br_stall = branch_d_i & (write_reg≠0 & match on rs_d_i/rt_d_i) for either of two sources:
  - regwrite_e_i with write_reg_e_i
  - memtoreg_m_i with write_reg_m_i
- MDU stall: mdu_stall = mdu_use_d_i & mdu_busy_o.
- Combined stall: stall_d = lw_stall | br_stall | mdu_stall.
  - stall_f_o = stall_d
  - en_d_o = ~stall_d
  - flush_e_o = stall_d
- Decode flush: flush_d_o = (pc_src_d_i | jump_d_i) & ~stall_d. A stalled branch holds in D and re-resolves next cycle; no flush while stalled.
- MDU FSM states: IDLE, BUSY.
  - IDLE + mdu_start_e_i: load cnt = (mdu_div_e_i ? DIV_LAT : MUL_LAT) - 1, go to BUSY.
  - BUSY with cnt≠0: cnt decrements.
  - BUSY with cnt==0: mdu_done_o = 1, next state IDLE.
  - cnt width = $clog2(DIV_LAT+1).
- mdu_start_e_i while BUSY: the start is ignored (no reload), and mdu_err_o sets and stays set until reset.
- stall_cnt_o increments each cycle stall_d=1 and holds at 2^CNT_W-1.

## Timing
- Stall and flush outputs are combinational from the inputs and the current state, valid in the same cycle.
- Reset values, after the reset edge: state IDLE, cnt 0, mdu_busy_o 0, mdu_done_o 0, mdu_err_o 0, stall_cnt_o 0.
- While reset_i is high, the MDU terms read as IDLE, so mdu_stall = 0.
- Start sampled at edge t. mdu_busy_o is high in cycles t+1 … t+LAT, and mdu_done_o is high in cycle t+LAT. A dependent D-stage instruction is released in cycle t+LAT+1.
- With MUL_LAT=1: BUSY for exactly one cycle, and mdu_done_o is high in that same cycle.
- Reset during BUSY: IDLE on the next edge, no mdu_done_o pulse.
- A start arriving in the same cycle as done (BUSY, cnt==0) sets mdu_err_o, is not accepted, and the FSM still goes to IDLE.
- All stall sources asserted together: the counter increments by one only; flush_e_o=1 and flush_d_o=0.

## Test plan
- Load-use: memtoreg_e=1, write_reg_e=8, rs_d=8 → stall_f=1, en_d=0, flush_e=1 for one cycle; stall_cnt 0→1. Same with write_reg_e=0 → no stall.
- Branch hazards:
  - branch_d=1, regwrite_e=1, write_reg_e=rt_d=9 → stall cycle.
  - Next cycle memtoreg_m=1, write_reg_m=9 → second stall.
  - Then pc_src_d=1 with no hazard → flush_d=1, flush_e=0.
- Divide: start with div=1 at edge t, mdu_use_d=1 held → busy for 32 cycles, done only in cycle t+32, en_d low through t+32 and high at t+33, stall_cnt=32.
- Multiply followed by a start while BUSY: mult at t, second start at t+2 → mdu_err_o=1 and sticky, busy still ends at t+4.
- Reset mid-divide at cycle t+10 → busy=0 next cycle, no done pulse, stall_cnt=0, err=0.
- Saturation: CNT_W=4, hold lw_stall for 20 cycles → stall_cnt_o stops at 15.
